lii_out_arbiter: RTL

Round-robin arbiter that shares one LII physical output channel between NIN logical HLS output streams. It sits between kernel-side output streams and the `lii_out_p0_*` phy port. Each beat is tagged with the source node ID and the granted stream's destination ID, and zero-extended to the packing width. Each grant holds for up to BURST beats, and a 2-entry output buffer keeps the output registered while sustaining 1 beat/cycle.

---
 rtl/lii_out_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lii_out_arbiter.sv
// Round-robin arbiter sharing one LII phy output among NIN HLS streams.
// Grants hold for up to BURST beats; a 2-entry buffer keeps the phy side registered.
module lii_out_arbiter #(
  parameter int               NIN     = 4,
  parameter int               DW      = 64,
  parameter int               PW      = 128,
  parameter int               BURST   = 16,
  parameter logic [7:0]       SRC_ID  = 8'h00,
  parameter logic [NIN*8-1:0] DST_MAP = {NIN{8'h00}}
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [NIN*DW-1:0] in_tdata,
  input  logic [NIN-1:0]    in_tvalid,
  output logic [NIN-1:0]    in_tready,
  output logic [PW-1:0]     lii_out_p0_tdata,
  output logic              lii_out_p0_tvalid,
  input  logic              lii_out_p0_tready,
  output logic [7:0]        lii_out_p0_src,
  output logic [7:0]        lii_out_p0_dst,
  output logic [NIN-1:0]    grant,
  output logic              busy
);

  localparam int GW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int CW = $clog2(BURST + 1);
  localparam int BW = DW + 8;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gidx_q, gidx_d;
  logic [GW-1:0] lptr_q, lptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    occ_q, occ_d;
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [BW-1:0] mem_q [2];

  logic          sel_vld;
  logic [GW-1:0] sel_idx;
  logic [GW:0]   cand;
  logic          has_room;
  logic          src_vld;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data;
  logic [7:0]    push_dst;
  logic [BW-1:0] head;

  // Search starts just after the last-granted stream so it ends up with lowest priority.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NIN; k++) begin
      cand = {1'b0, lptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NIN)) cand = cand - (GW+1)'(NIN);
      if (!sel_vld && in_tvalid[cand[GW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[GW-1:0];
      end
    end
  end

  assign has_room  = (occ_q != 2'd2);
  assign src_vld   = in_tvalid[gidx_q];
  assign push      = (state_q == GRANT) && src_vld && has_room;
  assign pop       = lii_out_p0_tvalid && lii_out_p0_tready;
  assign push_data = in_tdata[int'(gidx_q)*DW +: DW];
  assign push_dst  = DST_MAP[int'(gidx_q)*8 +: 8];

  always_comb begin
    in_tready = '0;
    grant     = '0;
    if (state_q == GRANT) begin
      grant[gidx_q]     = 1'b1;
      in_tready[gidx_q] = has_room;
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    lptr_d  = lptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = GRANT;
          gidx_d  = sel_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (push) cnt_d = cnt_q + CW'(1);
        // A full buffer stalls the grant but never releases it.
        if ((push && (cnt_q == CW'(BURST - 1))) || !src_vld) begin
          state_d = IDLE;
          lptr_d  = gidx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d  = occ_q;
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
    if (push && !pop)      occ_d = occ_q + 2'd1;
    else if (!push && pop) occ_d = occ_q - 2'd1;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      lptr_q  <= GW'(NIN - 1);
      cnt_q   <= '0;
      occ_q   <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      lptr_q  <= lptr_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wptr_q] <= {push_dst, push_data};
  end

  assign head              = mem_q[rptr_q];
  assign lii_out_p0_tvalid = (occ_q != 2'd0);
  assign busy              = (state_q == GRANT) || lii_out_p0_tvalid;

  always_comb begin
    lii_out_p0_tdata = '0;
    lii_out_p0_src   = 8'h00;
    lii_out_p0_dst   = 8'h00;
    if (lii_out_p0_tvalid) begin
      lii_out_p0_tdata[DW-1:0] = head[DW-1:0];
      lii_out_p0_src           = SRC_ID;
      lii_out_p0_dst           = head[BW-1 -: 8];
    end
  end

endmodule
